// File: rtl/asp_irq_ctrl.sv
// asp_irq_ctrl: interrupt controller for the ASP shell.
// Edge-detects the source lines into a pending register, applies the software
// enable mask, and presents one vector at a time on the host interrupt port.
// Software sees STATUS/ENABLE/FORCE/SENT_COUNT/ID through a 64-bit CSR slave.
//
// FSM states:
//   state  | meaning
//   S_IDLE | no request outstanding; picks the next candidate round-robin
//   S_REQ  | irq_req_valid high, vector held until the host accepts it
module asp_irq_ctrl #(
  parameter int NUM_IRQ_LINES = 4,
  parameter int IRQ_VEC_W = $clog2(NUM_IRQ_LINES),
  parameter int NUM_IRQ_USED = 3,
  parameter int CSR_DATA_WIDTH = 64,
  parameter int CSR_ADDR_WIDTH = 3,
  parameter logic [CSR_DATA_WIDTH-1:0] VERSION = 'h0001
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_IRQ_USED-1:0]       irq_in,
  input  logic [CSR_ADDR_WIDTH-1:0]     csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [CSR_DATA_WIDTH-1:0]     csr_writedata,
  input  logic [CSR_DATA_WIDTH/8-1:0]   csr_byteenable,
  output logic [CSR_DATA_WIDTH-1:0]     csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest,
  output logic                          irq_req_valid,
  output logic [IRQ_VEC_W-1:0]          irq_req_vector,
  input  logic                          irq_req_ready
);

  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_STATUS = CSR_ADDR_WIDTH'(0);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_ENABLE = CSR_ADDR_WIDTH'(1);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_FORCE  = CSR_ADDR_WIDTH'(2);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_SENT   = CSR_ADDR_WIDTH'(3);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_ID     = CSR_ADDR_WIDTH'(4);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                    state, state_next;
  logic [NUM_IRQ_USED-1:0]   irq_q;
  logic [NUM_IRQ_USED-1:0]   pending, pending_next;
  logic [NUM_IRQ_USED-1:0]   enable;
  logic [NUM_IRQ_USED-1:0]   in_service;
  logic [NUM_IRQ_USED-1:0]   rise, w1c, force_set, candidates, accept_vec;
  logic [31:0]               sent_count;
  logic [IRQ_VEC_W-1:0]      rr_ptr;
  logic [IRQ_VEC_W-1:0]      sel_vec, hi_vec, lo_vec;
  logic                      hi_found;
  logic                      load_vec;
  logic                      accept;
  logic                      rd_en, wr_en;
  logic [CSR_DATA_WIDTH-1:0] rd_mux;
  logic                      unused_bits;

  // Upper write-data bits and upper byte lanes carry nothing for this block.
  assign unused_bits = ^{csr_writedata[CSR_DATA_WIDTH-1:NUM_IRQ_USED],
                         csr_byteenable[CSR_DATA_WIDTH/8-1:1]};

  assign csr_waitrequest = reset;
  assign rd_en = csr_read && !csr_waitrequest;
  assign wr_en = csr_write && !csr_waitrequest && csr_byteenable[0];

  assign rise       = irq_in & ~irq_q;
  assign candidates = pending & enable & ~in_service;
  assign accept     = (state == S_REQ) && irq_req_ready;
  assign irq_req_valid = (state == S_REQ);

  // Decode W1C and FORCE strobes from byte 0 of a CSR write.
  always_comb begin
    w1c = '0;
    force_set = '0;
    if (wr_en) begin
      if (csr_address == ADDR_STATUS) w1c = csr_writedata[NUM_IRQ_USED-1:0];
      if (csr_address == ADDR_FORCE)  force_set = csr_writedata[NUM_IRQ_USED-1:0];
    end
  end

  // Set terms are OR-ed in after the clear so a same-cycle set wins.
  assign pending_next = (pending & ~w1c) | rise | force_set;

  // One-hot of the vector being accepted this cycle.
  always_comb begin
    accept_vec = '0;
    for (int i = 0; i < NUM_IRQ_USED; i++)
      accept_vec[i] = accept && (irq_req_vector == IRQ_VEC_W'(i));
  end

  // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_vec = '0;
    lo_vec = '0;
    for (int i = NUM_IRQ_USED - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        lo_vec = IRQ_VEC_W'(i);
        if (IRQ_VEC_W'(i) >= rr_ptr) begin
          hi_vec = IRQ_VEC_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel_vec = hi_found ? hi_vec : lo_vec;
  end

  // Request FSM next-state logic.
  always_comb begin
    state_next = state;
    load_vec = 1'b0;
    case (state)
      S_IDLE: begin
        if (|candidates) begin
          state_next = S_REQ;
          load_vec = 1'b1;
        end
      end
      S_REQ: begin
        if (irq_req_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register and held request vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      irq_req_vector <= '0;
    end else begin
      state <= state_next;
      if (load_vec) irq_req_vector <= sel_vec;
    end
  end

  // Interrupt bookkeeping: edge history, pending, mask, in-service, counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
      pending <= '0;
      enable <= '0;
      in_service <= '0;
      sent_count <= '0;
      rr_ptr <= '0;
    end else begin
      irq_q <= irq_in;
      pending <= pending_next;
      // in_service drops whenever its pending bit ends up clear.
      in_service <= (in_service | accept_vec) & pending_next;
      if (wr_en && (csr_address == ADDR_ENABLE))
        enable <= csr_writedata[NUM_IRQ_USED-1:0];
      if (accept) begin
        if (sent_count != 32'hFFFF_FFFF) sent_count <= sent_count + 32'd1;
        if (irq_req_vector == IRQ_VEC_W'(NUM_IRQ_USED - 1)) rr_ptr <= '0;
        else rr_ptr <= irq_req_vector + IRQ_VEC_W'(1);
      end
    end
  end

  // CSR read mux; reflects register values before this cycle's writes.
  always_comb begin
    rd_mux = '0;
    case (csr_address)
      ADDR_STATUS: rd_mux[NUM_IRQ_USED-1:0] = pending;
      ADDR_ENABLE: rd_mux[NUM_IRQ_USED-1:0] = enable;
      ADDR_SENT:   rd_mux[31:0] = sent_count;
      ADDR_ID:     rd_mux = VERSION;
      default:     rd_mux = '0;
    endcase
  end

  // Registered read response, one cycle after the accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      csr_readdata <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      csr_readdatavalid <= rd_en;
      if (rd_en) csr_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Testbench for asp_irq_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the controller.
module tb_asp_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  irq_in;
  logic [2:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [63:0] csr_writedata;
  logic [7:0]  csr_byteenable;
  logic [63:0] csr_readdata;
  logic        csr_readdatavalid;
  logic        csr_waitrequest;
  logic        irq_req_valid;
  logic [1:0]  irq_req_vector;
  logic        irq_req_ready;

  int n_checks = 0;
  int n_fail = 0;

  // model state
  logic [2:0]  m_pending, m_enable, m_insvc, m_irq_q;
  logic [31:0] m_sent;
  int          m_rr;
  logic        m_valid;
  int          m_vec;
  logic        m_rdv;
  logic [63:0] m_rdata;

  always #5 clk = ~clk;

  asp_irq_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .irq_in            (irq_in),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_byteenable    (csr_byteenable),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .csr_waitrequest   (csr_waitrequest),
    .irq_req_valid     (irq_req_valid),
    .irq_req_vector    (irq_req_vector),
    .irq_req_ready     (irq_req_ready)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_reg(input logic [2:0] addr);
    case (addr)
      3'd0: return {61'd0, m_pending};
      3'd1: return {61'd0, m_enable};
      3'd3: return {32'd0, m_sent};
      3'd4: return 64'h0001;
      default: return 64'd0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [2:0]  rise, w1c, fset, pend_n, cand, ins_n;
    logic [63:0] rd;
    if (reset) begin
      m_pending = 0; m_enable = 0; m_insvc = 0; m_irq_q = 0;
      m_sent = 0; m_rr = 0; m_valid = 0; m_vec = 0;
      m_rdv = 0; m_rdata = 0;
      return;
    end
    rise = irq_in & ~m_irq_q;
    w1c = 0;
    fset = 0;
    rd = model_reg(csr_address);
    cand = m_pending & m_enable & ~m_insvc;
    if (csr_write && csr_byteenable[0]) begin
      if (csr_address == 3'd0) w1c = csr_writedata[2:0];
      if (csr_address == 3'd2) fset = csr_writedata[2:0];
      if (csr_address == 3'd1) m_enable = csr_writedata[2:0];
    end
    pend_n = (m_pending & ~w1c) | rise | fset;
    ins_n = m_insvc;
    if (m_valid && irq_req_ready) ins_n[m_vec] = 1'b1;
    ins_n = ins_n & pend_n;
    if (m_valid) begin
      if (irq_req_ready) begin
        m_valid = 0;
        if (m_sent != 32'hFFFF_FFFF) m_sent = m_sent + 1;
        m_rr = (m_vec + 1) % 3;
      end
    end else if (cand != 0) begin
      for (int k = 2; k >= 0; k--)
        if (cand[(m_rr + k) % 3]) m_vec = (m_rr + k) % 3;
      m_valid = 1;
    end
    m_pending = pend_n;
    m_insvc = ins_n;
    m_irq_q = irq_in;
    m_rdv = csr_read;
    if (csr_read) m_rdata = rd;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_val("waitrequest", {63'd0, csr_waitrequest}, {63'd0, reset});
    check_val("req_valid", {63'd0, irq_req_valid}, {63'd0, m_valid});
    if (m_valid) check_val("req_vector", {62'd0, irq_req_vector}, 64'(m_vec));
    check_val("rdvalid", {63'd0, csr_readdatavalid}, {63'd0, m_rdv});
    if (m_rdv) check_val("rdata", csr_readdata, m_rdata);
  endtask

  task automatic csr_wr(input logic [2:0] addr, input logic [63:0] data, input logic [7:0] be);
    csr_address = addr; csr_writedata = data; csr_byteenable = be; csr_write = 1;
    step();
    csr_write = 0;
  endtask

  task automatic csr_rd(input string tag, input logic [2:0] addr, input logic [63:0] exp);
    csr_address = addr; csr_read = 1;
    step();
    csr_read = 0;
    check_val(tag, csr_readdata, exp);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (irq_req_valid) break;
      step();
    end
    check_val(tag, {63'd0, irq_req_valid}, 64'd1);
  endtask

  initial begin
    reset = 1; irq_in = 0; csr_address = 0; csr_read = 0; csr_write = 0;
    csr_writedata = 0; csr_byteenable = 8'hFF; irq_req_ready = 0;
    #1;
    repeat (3) step();
    reset = 0;

    // reset state and ID
    csr_rd("id_read", 3'd4, 64'h0001);
    csr_rd("status_after_reset", 3'd0, 64'd0);
    check_val("no_req_after_reset", {63'd0, irq_req_valid}, 64'd0);

    // single source with host back-pressure
    csr_wr(3'd1, 64'h7, 8'hFF);
    irq_in = 3'b010; step(); irq_in = 0;
    csr_rd("status_bit1", 3'd0, 64'h2);
    check_val("req_valid_bit1", {63'd0, irq_req_valid}, 64'd1);
    check_val("req_vector_bit1", {62'd0, irq_req_vector}, 64'd1);
    repeat (5) step();
    check_val("held_vector", {62'd0, irq_req_vector}, 64'd1);
    irq_req_ready = 1; step(); irq_req_ready = 0;
    check_val("valid_drop", {63'd0, irq_req_valid}, 64'd0);
    csr_rd("sent_count_1", 3'd3, 64'd1);

    // masked force, then unmask
    csr_wr(3'd0, 64'h7, 8'hFF);
    csr_wr(3'd1, 64'h0, 8'hFF);
    csr_wr(3'd2, 64'h4, 8'hFF);
    csr_rd("status_forced", 3'd0, 64'h4);
    csr_rd("force_reads_0", 3'd2, 64'h0);
    check_val("masked_no_req", {63'd0, irq_req_valid}, 64'd0);
    csr_wr(3'd1, 64'h4, 8'hFF);
    wait_valid("wait_forced");
    check_val("forced_vector", {62'd0, irq_req_vector}, 64'd2);
    irq_req_ready = 1; step(); irq_req_ready = 0;
    csr_wr(3'd0, 64'h7, 8'hFF);
    csr_wr(3'd1, 64'h7, 8'hFF);

    // two simultaneous edges, round robin from 0
    irq_in = 3'b101; irq_req_ready = 1;
    wait_valid("wait_pair");
    check_val("pair_first", {62'd0, irq_req_vector}, 64'd0);
    step();
    check_val("pair_gap", {63'd0, irq_req_valid}, 64'd0);
    step();
    check_val("pair_second_valid", {63'd0, irq_req_valid}, 64'd1);
    check_val("pair_second", {62'd0, irq_req_vector}, 64'd2);
    repeat (6) step();
    check_val("no_repeat", {63'd0, irq_req_valid}, 64'd0);
    csr_wr(3'd0, 64'h5, 8'hFF);
    irq_in = 0; step();
    irq_in = 3'b001;
    wait_valid("wait_resend");
    check_val("resend_vector", {62'd0, irq_req_vector}, 64'd0);
    step();
    irq_req_ready = 0; irq_in = 0;

    // set beats clear; byteenable gating
    csr_wr(3'd0, 64'h7, 8'hFF);
    step();
    irq_in = 3'b010;
    csr_wr(3'd0, 64'h2, 8'hFF);
    csr_rd("set_beats_clear", 3'd0, 64'h2);
    csr_wr(3'd0, 64'h7, 8'h00);
    csr_rd("be0_ignored", 3'd0, 64'h2);

    // reset while a request is outstanding
    wait_valid("wait_before_reset");
    irq_in = 0;
    reset = 1; step(); reset = 0;
    check_val("reset_drops_valid", {63'd0, irq_req_valid}, 64'd0);
    csr_rd("status_post_reset", 3'd0, 64'd0);
    csr_rd("enable_post_reset", 3'd1, 64'd0);
    csr_rd("sent_post_reset", 3'd3, 64'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) irq_in = 3'($urandom);
      csr_read = ($urandom_range(0, 3) == 0);
      csr_write = ($urandom_range(0, 5) == 0);
      csr_address = 3'($urandom_range(0, 7));
      csr_writedata = {$urandom, $urandom};
      csr_byteenable = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
      irq_req_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    reset = 0; csr_read = 0; csr_write = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
